// File: rtl/sw_sync_debounce.sv
// Switch input conditioner: two-flop synchroniser plus per-bit debounce counter
// for the switch bus, with registered accept-edge pulses on the go/next switch (bit 8).
module sw_sync_debounce #(
  parameter int N         = 9,
  parameter int DB_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] SW_raw,
  output logic [N-1:0] SW,
  output logic         sw8_rise,
  output logic         sw8_fall
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);
  localparam int              GO_BIT   = 8;

  logic [N-1:0]  sync1_q, sync2_q;
  logic [N-1:0]  sw_q, sw_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // A level is accepted only after it has disagreed with SW for DB_CYCLES
  // consecutive edges; any agreement restarts the count, so bounces vanish.
  always_comb begin
    sw_d = sw_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_LAST) sw_d[i]   = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d =  sw_d[GO_BIT] & ~sw_q[GO_BIT];
    fall_d = ~sw_d[GO_BIT] &  sw_q[GO_BIT];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the counter array is reset too, so a partial count never
  // survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= SW_raw;
      sync2_q <= sync1_q;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign SW       = sw_q;
  assign sw8_rise = rise_q;
  assign sw8_fall = fall_q;

endmodule
